// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl -- character LCD (HD44780-style, 8-bit bus) text controller.
//
// Keeps a shadow buffer of NUM_LINES*LINE_CHARS characters. The host writes
// characters into it through a valid/ready port. After power-up init, any
// change to the buffer (or a REFRESH pulse) triggers a full redraw pass.
//
// Ports
//   CLK_50MHZ  sole clock, rising edge
//   RST_N      asynchronous active-low reset
//   WR_VALID / WR_READY / WR_ADDR / WR_CHAR   host character write
//   REFRESH    single-cycle pulse forcing a full redraw
//   INIT_DONE  high once the init sequence has completed
//   BUSY       high unless idle with no pending redraw
//   LCD_DB, LCD_E, LCD_RS, LCD_RW              LCD bus (RW tied low)

package lcd_text_ctrl_pkg;
    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SET_ADDR, WR_CHAR} state_t;
    // Phases of a single bus transfer: setup (E low), E high, post-wait.
    typedef enum logic [1:0] {X_SETUP, X_EHI, X_WAIT} xphase_t;
endpackage

module lcd_text_ctrl #(
    parameter int NUM_LINES    = 2,
    parameter int LINE_CHARS   = 16,
    parameter int POWERUP_WAIT = 750000,
    parameter int INIT1_WAIT   = 205000,
    parameter int INIT2_WAIT   = 5000,
    parameter int E_PULSE      = 12,
    parameter int CMD_WAIT     = 2000,
    parameter int CLEAR_WAIT   = 82000,
    localparam int NCH         = NUM_LINES * LINE_CHARS,
    localparam int AW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          CLK_50MHZ,
    input  logic          RST_N,
    input  logic          WR_VALID,
    output logic          WR_READY,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [7:0]    WR_CHAR,
    input  logic          REFRESH,
    output logic          INIT_DONE,
    output logic          BUSY,
    output logic [7:0]    LCD_DB,
    output logic          LCD_E,
    output logic          LCD_RS,
    output logic          LCD_RW
);
    // All waits are assumed >= 1 clock.
    localparam logic [31:0] PW_M1 = 32'(POWERUP_WAIT - 1);
    localparam logic [31:0] EP_M1 = 32'(E_PULSE - 1);
    localparam logic [31:0] LC_M1 = 32'(LINE_CHARS - 1);
    localparam logic [31:0] CMD_W = 32'(CMD_WAIT);

    lcd_text_ctrl_pkg::state_t  state_q, state_d;
    lcd_text_ctrl_pkg::xphase_t ph_q, ph_d;

    logic [31:0] cnt_q, cnt_d, wait_q, wait_d, col_q, col_d;
    logic [2:0]  step_q, step_d;
    logic        line_q, line_d;
    logic [7:0]  db_q, db_d;
    logic        rs_q, rs_d, e_q, e_d, done_q, done_d, dirty_q, dirty_d, rdy_q;
    logic [7:0]  mem [NCH];

    logic        wr_ok, pass_start, xfer_end, ld, ld_rs;
    logic [7:0]  ld_db, rd_char;
    logic [31:0] ld_wait, rd_col, rd_idx;

    function automatic logic [7:0] init_db(input logic [2:0] s);
        case (s)
            3'd0, 3'd1, 3'd2, 3'd3: init_db = 8'h38;
            3'd4:                   init_db = 8'h06;
            3'd5:                   init_db = 8'h0C;
            default:                init_db = 8'h01;
        endcase
    endfunction

    function automatic logic [31:0] init_wait(input logic [2:0] s);
        case (s)
            3'd0:    init_wait = 32'(CMD_WAIT + INIT1_WAIT);
            3'd1:    init_wait = 32'(CMD_WAIT + INIT2_WAIT);
            3'd6:    init_wait = 32'(CLEAR_WAIT);
            default: init_wait = CMD_W;
        endcase
    endfunction

    assign wr_ok = WR_VALID & rdy_q & (32'(WR_ADDR) < 32'(NCH));

    // Next character to send: column 0 after SET_ADDR, else the following one.
    // Sampled when the transfer's setup cycle is loaded.
    assign rd_col  = (state_q == lcd_text_ctrl_pkg::SET_ADDR) ? 32'd0 : col_q + 32'd1;
    assign rd_idx  = 32'(line_q) * 32'(LINE_CHARS) + rd_col;
    assign rd_char = mem[rd_idx[AW-1:0]];

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        step_d     = step_q;
        col_d      = col_q;
        line_d     = line_q;
        db_d       = db_q;
        rs_d       = rs_q;
        e_d        = e_q;
        done_d     = done_q;
        pass_start = 1'b0;
        xfer_end   = 1'b0;
        ld         = 1'b0;
        ld_db      = db_q;
        ld_rs      = 1'b0;
        ld_wait    = CMD_W;

        // Bus transfer sequencer, active in any transferring state.
        if (state_q inside {lcd_text_ctrl_pkg::INIT, lcd_text_ctrl_pkg::SET_ADDR,
                            lcd_text_ctrl_pkg::WR_CHAR}) begin
            case (ph_q)
                lcd_text_ctrl_pkg::X_SETUP: begin
                    ph_d  = lcd_text_ctrl_pkg::X_EHI;
                    e_d   = 1'b1;
                    cnt_d = 32'd0;
                end
                lcd_text_ctrl_pkg::X_EHI: begin
                    if (cnt_q == EP_M1) begin
                        ph_d  = lcd_text_ctrl_pkg::X_WAIT;
                        e_d   = 1'b0;
                        cnt_d = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: begin
                    if (cnt_q == wait_q - 32'd1) xfer_end = 1'b1;
                    else                         cnt_d    = cnt_q + 32'd1;
                end
            endcase
        end

        case (state_q)
            lcd_text_ctrl_pkg::PWR_WAIT: begin
                if (cnt_q == PW_M1) begin
                    state_d = lcd_text_ctrl_pkg::INIT;
                    step_d  = 3'd0;
                    ld      = 1'b1;
                    ld_db   = init_db(3'd0);
                    ld_wait = init_wait(3'd0);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            lcd_text_ctrl_pkg::INIT: begin
                if (xfer_end) begin
                    if (step_q == 3'd6) begin
                        state_d = lcd_text_ctrl_pkg::IDLE;
                        done_d  = 1'b1;
                    end else begin
                        step_d  = step_q + 3'd1;
                        ld      = 1'b1;
                        ld_db   = init_db(step_q + 3'd1);
                        ld_wait = init_wait(step_q + 3'd1);
                    end
                end
            end
            lcd_text_ctrl_pkg::IDLE: begin
                if (dirty_q || REFRESH) begin
                    pass_start = 1'b1;
                    state_d    = lcd_text_ctrl_pkg::SET_ADDR;
                    line_d     = 1'b0;
                    ld         = 1'b1;
                    ld_db      = 8'h80;
                end
            end
            lcd_text_ctrl_pkg::SET_ADDR: begin
                if (xfer_end) begin
                    state_d = lcd_text_ctrl_pkg::WR_CHAR;
                    col_d   = 32'd0;
                    ld      = 1'b1;
                    ld_db   = rd_char;
                    ld_rs   = 1'b1;
                end
            end
            default: begin // WR_CHAR
                if (xfer_end) begin
                    if (col_q != LC_M1) begin
                        col_d = col_q + 32'd1;
                        ld    = 1'b1;
                        ld_db = rd_char;
                        ld_rs = 1'b1;
                    end else if (32'(line_q) == 32'(NUM_LINES - 1)) begin
                        state_d = lcd_text_ctrl_pkg::IDLE;
                    end else begin
                        state_d = lcd_text_ctrl_pkg::SET_ADDR;
                        line_d  = 1'b1;
                        ld      = 1'b1;
                        ld_db   = 8'hC0;
                    end
                end
            end
        endcase

        if (ld) begin
            ph_d   = lcd_text_ctrl_pkg::X_SETUP;
            cnt_d  = 32'd0;
            e_d    = 1'b0;
            db_d   = ld_db;
            rs_d   = ld_rs;
            wait_d = ld_wait;
        end

        // Anything arriving while a pass runs (or before init ends) is kept
        // for one more pass; the request that starts a pass is consumed by it.
        if (pass_start) dirty_d = wr_ok;
        else            dirty_d = dirty_q | wr_ok | REFRESH;
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= lcd_text_ctrl_pkg::PWR_WAIT;
            ph_q    <= lcd_text_ctrl_pkg::X_SETUP;
            cnt_q   <= 32'd0;
            wait_q  <= 32'd0;
            col_q   <= 32'd0;
            step_q  <= 3'd0;
            line_q  <= 1'b0;
            db_q    <= 8'h00;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
            dirty_q <= 1'b1;
            rdy_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) mem[i] <= 8'h20;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            col_q   <= col_d;
            step_q  <= step_d;
            line_q  <= line_d;
            db_q    <= db_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            done_q  <= done_d;
            dirty_q <= dirty_d;
            rdy_q   <= 1'b1;
            if (wr_ok) mem[WR_ADDR] <= WR_CHAR;
        end
    end

    assign WR_READY  = rdy_q;
    assign INIT_DONE = done_q;
    assign BUSY      = !((state_q == lcd_text_ctrl_pkg::IDLE) && !dirty_q);
    assign LCD_DB    = db_q;
    assign LCD_E     = e_q;
    assign LCD_RS    = rs_q;
    assign LCD_RW    = 1'b0;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl with a transfer scoreboard: expected bus
// transfers (RS, DB, low-time before E rise) are queued as stimulus is
// applied and checked at every rising LCD_E.
module tb_lcd_text_ctrl;
    localparam int PW = 100, I1 = 50, I2 = 20, EP = 2, CW = 10, CLW = 30;

    logic       clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v1 = 1'b0, rf1 = 1'b0, v2 = 1'b0, rf2 = 1'b0;
    logic [2:0] a1 = '0, a2 = '0;
    logic [7:0] ch = '0;
    logic       rdy1, done1, busy1, e1, rs1, rw1;
    logic       rdy2, done2, busy2, e2, rs2, rw2;
    logic [7:0] db1, db2;

    lcd_text_ctrl #(.NUM_LINES(2), .LINE_CHARS(4), .POWERUP_WAIT(PW), .INIT1_WAIT(I1),
        .INIT2_WAIT(I2), .E_PULSE(EP), .CMD_WAIT(CW), .CLEAR_WAIT(CLW)) dut1 (
        .CLK_50MHZ(clk), .RST_N(rst_n), .WR_VALID(v1), .WR_READY(rdy1), .WR_ADDR(a1),
        .WR_CHAR(ch), .REFRESH(rf1), .INIT_DONE(done1), .BUSY(busy1), .LCD_DB(db1),
        .LCD_E(e1), .LCD_RS(rs1), .LCD_RW(rw1));

    // Second instance with a non-power-of-two buffer so out-of-range addresses exist.
    lcd_text_ctrl #(.NUM_LINES(2), .LINE_CHARS(3), .POWERUP_WAIT(PW), .INIT1_WAIT(I1),
        .INIT2_WAIT(I2), .E_PULSE(EP), .CMD_WAIT(CW), .CLEAR_WAIT(CLW)) dut2 (
        .CLK_50MHZ(clk), .RST_N(rst_n), .WR_VALID(v2), .WR_READY(rdy2), .WR_ADDR(a2),
        .WR_CHAR(ch), .REFRESH(rf2), .INIT_DONE(done2), .BUSY(busy2), .LCD_DB(db2),
        .LCD_E(e2), .LCD_RS(rs2), .LCD_RW(rw2));

    int ncomp = 0, nfail = 0;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         gap;   // expected E-low clocks before this rise; 0 = unchecked
    } xfer_t;
    xfer_t      expq[$];
    logic [7:0] mbuf [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] db, input int gap);
        xfer_t x;
        x.rs = rs; x.db = db; x.gap = gap;
        expq.push_back(x);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, 0);
        push(1'b0, 8'h38, CW + I1 + 1);
        push(1'b0, 8'h38, CW + I2 + 1);
        push(1'b0, 8'h38, CW + 1);
        push(1'b0, 8'h06, CW + 1);
        push(1'b0, 8'h0C, CW + 1);
        push(1'b0, 8'h01, CW + 1);
    endtask

    task automatic push_pass(input int first_gap);
        for (int l = 0; l < 2; l++) begin
            push(1'b0, (l == 0) ? 8'h80 : 8'hC0, (l == 0) ? first_gap : CW + 1);
            for (int c = 0; c < 4; c++) push(1'b1, mbuf[l*4+c], CW + 1);
        end
    endtask

    task automatic wr1(input logic [2:0] a, input logic [7:0] c);
        v1 = 1'b1; a1 = a; ch = c;
        @(posedge clk); #1 v1 = 1'b0;
    endtask

    task automatic pulse_rf1();
        rf1 = 1'b1;
        @(posedge clk); #1 rf1 = 1'b0;
    endtask

    task automatic wait_idle1(input int budget);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (busy1 && n < budget);
        chk("idle1_reached", busy1, 1'b0);
    endtask

    task automatic wait_idle2(input int budget);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (busy2 && n < budget);
        chk("idle2_reached", busy2, 1'b0);
    endtask

    task automatic first_rise_and_init();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!e1 && n < 500);
        chk("first_e_rise_clocks", n, PW + 1);
        chk("ready_during_init", rdy1, 1'b1);
        n = 0;
        while (!done1 && n < 3000) begin @(posedge clk); #1; n++; end
        chk("init_done", done1, 1'b1);
        chk("init_seq_sent", expq.size(), 0);
    endtask

    // Scoreboard monitor for dut1, sampled on the falling edge.
    logic  ep = 1'b0;
    int    lo = 0, hi = 0;
    xfer_t xm;
    always @(negedge clk) begin
        if (!rst_n) begin
            ep <= 1'b0; lo <= 0; hi <= 0;
        end else if (e1 && !ep) begin
            chk("xfer_expected", expq.size() != 0, 1'b1);
            chk("rw_low", rw1, 1'b0);
            if (expq.size() != 0) begin
                xm = expq.pop_front();
                chk("xfer_db", db1, xm.db);
                chk("xfer_rs", rs1, xm.rs);
                if (xm.gap != 0) chk("xfer_gap", lo, xm.gap);
            end
            hi <= 1; ep <= 1'b1;
        end else if (e1) begin
            hi <= hi + 1;
        end else if (ep) begin
            chk("e_width", hi, EP);
            lo <= 1; ep <= 1'b0;
        end else begin
            lo <= lo + 1;
        end
    end

    // Transfer counter for dut2: total rises and characters that are not blank.
    logic ep2 = 1'b0;
    int   n2 = 0, bad2 = 0;
    always @(negedge clk) begin
        ep2 <= e2;
        if (e2 && !ep2) begin
            n2 <= n2 + 1;
            if (rs2 && db2 != 8'h20) bad2 <= bad2 + 1;
        end
    end

    initial begin
        int n, nb, b2, bb2;
        for (int i = 0; i < 8; i++) mbuf[i] = 8'h20;

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_db", db1, 8'h00);
        chk("rst_e", e1, 1'b0);
        chk("rst_rs", rs1, 1'b0);
        chk("rst_rw", rw1, 1'b0);
        chk("rst_init_done", done1, 1'b0);
        chk("rst_busy", busy1, 1'b1);
        chk("rst_ready", rdy1, 1'b0);

        // Power-up wait, init sequence, first redraw of blank buffer
        push_init();
        @(negedge clk) rst_n = 1'b1;
        first_rise_and_init();
        push_pass(CLW + 2);
        chk("busy_pending_pass", busy1, 1'b1);
        wait_idle1(1000);
        chk("pass1_drained", expq.size(), 0);
        wait_idle2(1000);

        // Write 'D' at addr 5 while idle
        mbuf[5] = 8'h44;
        push_pass(0);
        wr1(3'd5, 8'h44);
        repeat (3) @(posedge clk); #1;
        chk("ready_during_pass", rdy1, 1'b1);
        chk("busy_during_pass", busy1, 1'b1);
        wait_idle1(1000);
        chk("pass_write5_drained", expq.size(), 0);

        // Write + REFRESH during a pass -> exactly one extra pass
        push_pass(0);
        pulse_rf1();
        n = 0;
        while (expq.size() > 7 && n < 500) begin @(posedge clk); #1; n++; end
        chk("midpass_reached", expq.size(), 7);
        mbuf[1] = 8'h41;
        wr1(3'd1, 8'h41);
        pulse_rf1();
        push_pass(CW + 2);
        wait_idle1(2000);
        chk("two_passes_drained", expq.size(), 0);
        repeat (40) @(posedge clk); #1;
        chk("no_third_pass", busy1, 1'b0);

        // Out-of-range write on dut2: no pass, buffer unchanged
        b2 = n2; bb2 = bad2;
        v2 = 1'b1; a2 = 3'd6; ch = 8'h55;
        @(posedge clk); #1 v2 = 1'b0;
        nb = 0;
        repeat (30) begin @(posedge clk); #1; if (busy2) nb++; end
        chk("oor_no_busy", nb, 0);
        chk("oor_no_xfer", n2 - b2, 0);
        chk("oor_ready", rdy2, 1'b1);
        rf2 = 1'b1;
        @(posedge clk); #1 rf2 = 1'b0;
        wait_idle2(1000);
        chk("oor_refresh_len", n2 - b2, 8);
        chk("oor_buf_blank", bad2 - bb2, 0);

        // Reset while E high: E drops at once, full init restarts
        push_pass(0);
        pulse_rf1();
        n = 0;
        while (!e1 && n < 200) begin @(posedge clk); #1; n++; end
        chk("e_high_seen", e1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_e", e1, 1'b0);
        chk("rst2_init_done", done1, 1'b0);
        chk("rst2_busy", busy1, 1'b1);
        chk("rst2_ready", rdy1, 1'b0);
        expq.delete();
        for (int i = 0; i < 8; i++) mbuf[i] = 8'h20;
        repeat (2) @(posedge clk);
        push_init();
        @(negedge clk) rst_n = 1'b1;
        first_rise_and_init();
        push_pass(CLW + 2);
        wait_idle1(1000);
        chk("post_reset_pass_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
